// File: rtl/l1_l2_arbiter_if.sv
// L1 <-> L2 request bus shared by the I-cache and D-cache controllers.
// The slave modport is the arbiter view; master is the view of the L1/L2 side.
interface l1_l2_arbiter_if #(
  parameter int unsigned TAG_W = 21,
  parameter int unsigned IDX_W = 5
) ();
  logic             read_I_L2;
  logic [IDX_W-1:0] index_I_L2;
  logic [TAG_W-1:0] tag_I_L2;
  logic             read_D_L2;
  logic             write_D_L2;
  logic [IDX_W-1:0] index_D_L2;
  logic [TAG_W-1:0] tag_D_L2;
  logic [TAG_W-1:0] write_tag_D_L2;
  logic             ready_L2;
  logic             ready_L2_I;
  logic             ready_L2_D;
  logic             read_L2;
  logic             write_L2;
  logic [IDX_W-1:0] index_L2;
  logic [TAG_W-1:0] tag_L2;
  logic             grant_D;

  modport slave (
    input  read_I_L2, index_I_L2, tag_I_L2,
    input  read_D_L2, write_D_L2, index_D_L2, tag_D_L2, write_tag_D_L2,
    input  ready_L2,
    output ready_L2_I, ready_L2_D, read_L2, write_L2, index_L2, tag_L2, grant_D
  );

  modport master (
    output read_I_L2, index_I_L2, tag_I_L2,
    output read_D_L2, write_D_L2, index_D_L2, tag_D_L2, write_tag_D_L2,
    output ready_L2,
    input  ready_L2_I, ready_L2_D, read_L2, write_L2, index_L2, tag_L2, grant_D
  );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Arbitrates the single L2 port between I-cache refills and D-cache refills/write-backs.
// Grant is held until the serviced request level drops, so level requests are serviced once.
module l1_l2_arbiter #(
  parameter int unsigned TAG_W = 21,
  parameter int unsigned IDX_W = 5
) (
  input  logic           clk,
  input  logic           nrst,
  l1_l2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StBusyI   = 2'b01,
    StBusyD   = 2'b10,
    StRelease = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   op_wr_q, op_wr_d;
  logic   hold_d_q, hold_d_d;

  logic req_i, req_d, grant_to_d, serviced;

  logic [IDX_W-1:0] index_out;
  logic [TAG_W-1:0] tag_out;

  assign req_i = bus.read_I_L2;
  assign req_d = bus.read_D_L2 | bus.write_D_L2;

  // After a write-back, D keeps the port so its allocate read is not split from the eviction.
  assign grant_to_d = req_d & (hold_d_q | ~req_i | ~last_d_q);

  // Only the request that was actually serviced must drop before re-arbitrating.
  assign serviced = last_d_q ? (op_wr_q ? bus.write_D_L2 : bus.read_D_L2) : bus.read_I_L2;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
      op_wr_q  <= 1'b0;
      hold_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      op_wr_q  <= op_wr_d;
      hold_d_q <= hold_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    op_wr_d  = op_wr_q;
    hold_d_d = hold_d_q;
    unique case (state_q)
      StIdle: begin
        if (req_i | req_d) begin
          if (grant_to_d) begin
            state_d  = StBusyD;
            op_wr_d  = bus.write_D_L2;
            hold_d_d = 1'b0;
          end else begin
            state_d = StBusyI;
          end
        end
      end
      StBusyI: begin
        if (bus.ready_L2) begin
          state_d  = StRelease;
          last_d_d = 1'b0;
        end
      end
      StBusyD: begin
        if (bus.ready_L2) begin
          state_d  = StRelease;
          last_d_d = 1'b1;
          hold_d_d = op_wr_q;
        end
      end
      StRelease: begin
        if (!serviced) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.read_L2    = 1'b0;
    bus.write_L2   = 1'b0;
    bus.ready_L2_I = 1'b0;
    bus.ready_L2_D = 1'b0;
    bus.grant_D    = 1'b0;
    index_out      = '0;
    tag_out        = '0;
    unique case (state_q)
      StBusyI: begin
        bus.read_L2    = bus.read_I_L2;
        bus.ready_L2_I = bus.ready_L2;
        index_out      = bus.index_I_L2;
        tag_out        = bus.tag_I_L2;
      end
      StBusyD: begin
        bus.read_L2    = bus.read_D_L2 & ~op_wr_q;
        bus.write_L2   = bus.write_D_L2 & op_wr_q;
        bus.ready_L2_D = bus.ready_L2;
        bus.grant_D    = 1'b1;
        index_out      = bus.index_D_L2;
        tag_out        = op_wr_q ? bus.write_tag_D_L2 : bus.tag_D_L2;
      end
      default: ;
    endcase
    bus.index_L2 = index_out;
    bus.tag_L2   = tag_out;
  end

endmodule
